// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
//   Shared types and constants for the RV front end.
//   XLEN / INSTR_W   : datapath and instruction widths
//   RESET_VECTOR     : default fetch address after reset
//   NOP_INSTR        : canonical no-op (addi x0, x0, 0)
//   fetch_entry_t    : fetched instruction word paired with its byte address
//   is_aligned()     : true when a byte address is word aligned
// ---------------------------------------------------------------------------
package rv_pkg;

    localparam int          XLEN         = 32;
    localparam int          INSTR_W      = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } fetch_entry_t;

    function automatic logic is_aligned(input logic [XLEN-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// ---------------------------------------------------------------------------
// fetch_buffer
//   DEPTH-entry synchronous FIFO of fetch_entry_t. Built as a shift queue so
//   slot 0 is always the head and drives the outputs straight from flops.
//   Ports:
//     clock, reset_n   : clock, asynchronous active-low reset
//     flush            : drop every entry (wins over push/pop)
//     push, push_entry : enqueue one entry (caller guarantees space)
//     pop              : dequeue the head
//     count            : number of valid entries
//     head_valid, head : registered head entry
// ---------------------------------------------------------------------------
module fetch_buffer
    import rv_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output logic [CW-1:0] count,
    output logic         head_valid,
    output fetch_entry_t head
);

    logic [CW-1:0] count_reg;
    logic          pop_eff;
    logic          push_eff;

    // Guard against misuse so the count can never wrap.
    assign pop_eff  = pop && (count_reg != '0);
    assign push_eff = push && (pop_eff || (count_reg < CW'(DEPTH)));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            fetch_entry_t slot_reg;
            fetch_entry_t shift_src;

            if (gi < DEPTH - 1) begin : g_shift
                assign shift_src = g_slot[gi+1].slot_reg;
            end else begin : g_last
                assign shift_src = slot_reg;
            end

            // On pop every slot takes its neighbour; a simultaneous push lands
            // in the slot just vacated at the tail (count-1).
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    slot_reg <= '0;
                end else if (!flush) begin
                    if (pop_eff) begin
                        if (push_eff && (count_reg == CW'(gi + 1)))
                            slot_reg <= push_entry;
                        else
                            slot_reg <= shift_src;
                    end else if (push_eff && (count_reg == CW'(gi))) begin
                        slot_reg <= push_entry;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else if (flush) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CW'(push_eff) - CW'(pop_eff);
        end
    end

    assign count      = count_reg;
    assign head_valid = (count_reg != '0);
    assign head       = g_slot[0].slot_reg;

endmodule

// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Owns the PC, issues word-aligned reads to a 1-cycle-latency instruction
//   memory and hands returned words (with their PC) to decode via valid/ready.
//   Ports:
//     clock, reset_n           : clock, asynchronous active-low reset
//     imem_address             : byte address (= pc every cycle)
//     imem_data_in             : constant 0 (fetch never writes)
//     imem_read_write          : constant 0 (read)
//     imem_data_out            : word for the address sampled on the prior edge
//     redirect_valid/_pc       : one-cycle redirect pulse and target
//     instr_valid/_ready       : handshake towards decode
//     instr, instr_pc          : instruction word and its byte address
//     fetch_misaligned         : sticky, set by an unaligned redirect target
// ---------------------------------------------------------------------------
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_VECTOR,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [31:0] imem_address,
    output logic [31:0] imem_data_in,
    output logic        imem_read_write,
    input  logic [31:0] imem_data_out,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_misaligned
);

    localparam int CW = $clog2(BUF_DEPTH + 1);

    logic [31:0]   pc_reg;
    logic          inflight_reg;
    logic [31:0]   inflight_pc_reg;
    logic          misaligned_reg;

    logic [CW-1:0] buf_count;
    logic          buf_valid;
    fetch_entry_t  buf_head;
    fetch_entry_t  resp_entry;
    logic          pop;
    logic          issue;
    logic [CW:0]   occupancy;

    assign pop = instr_valid && instr_ready;

    // Credit check: entries held plus the word still in flight, less the one
    // leaving this cycle, must leave room for the word we are about to request.
    assign occupancy = {1'b0, buf_count} + (CW+1)'(inflight_reg) - (CW+1)'(pop);
    assign issue     = !misaligned_reg && !redirect_valid
                       && (occupancy < (CW+1)'(BUF_DEPTH));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
            misaligned_reg  <= 1'b0;
        end else if (redirect_valid) begin
            // Outstanding response is abandoned; its data is never pushed.
            pc_reg         <= redirect_pc;
            inflight_reg   <= 1'b0;
            misaligned_reg <= !is_aligned(redirect_pc);
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= pc_reg;
                pc_reg          <= pc_reg + 32'd4;
            end
        end
    end

    assign resp_entry.instr = imem_data_out;
    assign resp_entry.pc    = inflight_pc_reg;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buffer (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (redirect_valid),
        .push       (inflight_reg && !redirect_valid),
        .push_entry (resp_entry),
        .pop        (pop && !redirect_valid),
        .count      (buf_count),
        .head_valid (buf_valid),
        .head       (buf_head)
    );

    assign imem_address     = pc_reg;
    assign imem_data_in     = 32'h0;
    assign imem_read_write  = 1'b0;
    assign instr_valid      = buf_valid;
    assign instr            = buf_head.instr;
    assign instr_pc         = buf_head.pc;
    assign fetch_misaligned = misaligned_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench. The memory model returns word address (addr >> 2) one
//   cycle after the address is presented, so every fetched instr must equal
//   its instr_pc >> 2. Outputs are sampled and inputs driven on the falling
//   edge. While streaming, the head entry trails the fetch address by 8.
// ---------------------------------------------------------------------------
module tb_instr_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic [31:0] imem_address;
    logic [31:0] imem_data_in;
    logic        imem_read_write;
    logic [31:0] imem_data_out;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        fetch_misaligned;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_pc;

    instr_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .imem_address     (imem_address),
        .imem_data_in     (imem_data_in),
        .imem_read_write  (imem_read_write),
        .imem_data_out    (imem_data_out),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .instr_valid      (instr_valid),
        .instr_ready      (instr_ready),
        .instr            (instr),
        .instr_pc         (instr_pc),
        .fetch_misaligned (fetch_misaligned)
    );

    always #5 clock = ~clock;

    // Synchronous-read instruction memory: word[i] = i.
    always @(posedge clock) imem_data_out <= {2'b00, imem_address[31:2]};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        else
            n_pass++;
    endtask

    task automatic expect_instr(input string tag, input logic [31:0] pc);
        logic [31:0] word;
        logic [31:0] addr;
        word = {2'b00, pc[31:2]};
        addr = pc + 32'd8;
        check({tag, ".valid"}, {31'b0, instr_valid}, 32'd1);
        check({tag, ".pc"}, instr_pc, pc);
        check({tag, ".instr"}, instr, word);
        check({tag, ".addr"}, imem_address, addr);
        $display("txn %s: instr_pc=%h instr=%h addr=%h", tag, instr_pc, instr, imem_address);
    endtask

    // Consume n entries with ready=1, one per cycle, no gaps.
    task automatic stream(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            expect_instr(tag, exp_pc);
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    // Hold ready low for n+1 cycles; head must not move, fetch must stop.
    task automatic stall(input string tag, input int n, input bit resume);
        @(negedge clock);
        instr_ready = 1'b0;
        expect_instr(tag, exp_pc);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            expect_instr(tag, exp_pc);
            check({tag, ".rw"}, {31'b0, imem_read_write}, 32'd0);
        end
        check({tag, ".count"}, {30'b0, dut.u_buffer.count_reg}, 32'd2);
        if (resume) begin
            instr_ready = 1'b1;
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    // Single redirect pulse; ready is raised one cycle after the pulse.
    task automatic redirect(input string tag, input logic [31:0] target);
        @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        @(negedge clock);
        redirect_valid = 1'b0;
        instr_ready    = 1'b1;
        check({tag, ".v1"}, {31'b0, instr_valid}, 32'd0);
        check({tag, ".addr"}, imem_address, target);
        check({tag, ".mis"}, {31'b0, fetch_misaligned}, {31'b0, (target[1:0] != 2'b00)});
        @(negedge clock);
        check({tag, ".v2"}, {31'b0, instr_valid}, 32'd0);
        $display("txn %s: redirect to %h", tag, target);
        exp_pc = target;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clock          = 1'b0;
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst.valid", {31'b0, instr_valid}, 32'd0);
        check("rst.instr", instr, 32'd0);
        check("rst.pc", instr_pc, 32'd0);
        check("rst.mis", {31'b0, fetch_misaligned}, 32'd0);
        check("rst.addr", imem_address, 32'd0);
        check("rst.rw", {31'b0, imem_read_write}, 32'd0);
        check("rst.din", imem_data_in, 32'd0);

        // Release: cycle 0 addr 0, cycle 1 addr 4, first instr at cycle 2.
        reset_n = 1'b1;
        check("c0.addr", imem_address, 32'd0);
        @(negedge clock);
        check("c1.addr", imem_address, 32'd4);
        check("c1.valid", {31'b0, instr_valid}, 32'd0);
        exp_pc = 32'd0;
        stream("stream", 6);

        // Backpressure, then resume without gap/skip/duplicate.
        stall("stall", 6, 1'b1);
        stream("resume", 4);

        // Redirect coincident with a pop (ready=1 during pulse).
        redirect("redir_pop", 32'h0000_0100);
        stream("t100", 3);

        // Redirect while the buffer is full (ready low).
        stall("full", 3, 1'b0);
        redirect("redir_full", 32'h0000_0140);
        stream("t140", 2);

        // Two consecutive redirects: only the second target is fetched.
        @(negedge clock);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        @(negedge clock);
        redirect_pc    = 32'h0000_0400;
        check("b2b.v0", {31'b0, instr_valid}, 32'd0);
        @(negedge clock);
        redirect_valid = 1'b0;
        check("b2b.v1", {31'b0, instr_valid}, 32'd0);
        check("b2b.addr", imem_address, 32'h0000_0400);
        @(negedge clock);
        check("b2b.v2", {31'b0, instr_valid}, 32'd0);
        exp_pc = 32'h0000_0400;
        stream("t400", 2);

        // Misaligned redirect halts fetch until an aligned redirect.
        redirect("redir_mis", 32'h0000_0102);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("mis.valid", {31'b0, instr_valid}, 32'd0);
            check("mis.flag", {31'b0, fetch_misaligned}, 32'd1);
            check("mis.addr", imem_address, 32'h0000_0102);
        end
        redirect("redir_fix", 32'h0000_0200);
        stream("t200", 3);

        // PC wrap at the top of the address space.
        redirect("redir_wrap", 32'hFFFF_FFFC);
        stream("wrap", 3);

        // Reset mid-stream.
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("mrst.valid", {31'b0, instr_valid}, 32'd0);
        check("mrst.instr", instr, 32'd0);
        check("mrst.pc", instr_pc, 32'd0);
        check("mrst.addr", imem_address, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        check("mrst.c0", imem_address, 32'd0);
        @(negedge clock);
        check("mrst.c1", {31'b0, instr_valid}, 32'd0);
        exp_pc = 32'd0;
        stream("restart", 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
